dctq_quant_ctrl: RTL and testbench

Sequencer that runs one 8x8 block (64 coefficients) of signed DCT output through the shared 8-stage pipelined 11x8 signed multiplier to produce quantized coefficients. It sits between the coefficient buffer and the entropy-coding input:
- reads coefficients by address;
- pairs each with its quantization reciprocal from an internal 64-entry table;
- issues one multiply per cycle and tracks in-flight operations;
- rounds and scales each product and emits it tagged with its index.

---
 rtl/dctq_quant_ctrl.sv | 121 ++++++++++++
 tb/tb_dctq_quant_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dctq_quant_ctrl.sv
// dctq_quant_ctrl: sequences one 8x8 block of signed DCT coefficients through
// an external pipelined signed multiplier. Each coefficient is paired with its
// reciprocal from an internal table. The product is rounded half-up and
// scaled, then emitted with its index.
module dctq_quant_ctrl #(
  parameter int N_COEF  = 64,
  parameter int MUL_LAT = 8,
  parameter int SHIFT   = 7
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              coef_rd,
  output logic [$clog2(N_COEF)-1:0]         coef_addr,
  input  logic [10:0]                       coef_data,
  input  logic                              q_wr_en,
  input  logic [$clog2(N_COEF)-1:0]         q_wr_addr,
  input  logic [7:0]                        q_wr_data,
  output logic [10:0]                       mul_n1,
  output logic [7:0]                        mul_n2,
  input  logic [18:0]                       mul_result,
  output logic                              out_valid,
  output logic [$clog2(N_COEF)-1:0]         out_idx,
  output logic [11:0]                       out_data
);

  localparam int IDX_W  = $clog2(N_COEF);
  // Tracking depth: one cycle for the read, one for the operand register,
  // then the multiplier latency. The tail lines up with mul_result.
  localparam int STAGES = 2 + MUL_LAT;
  localparam logic [IDX_W-1:0]   LAST = IDX_W'(N_COEF - 1);
  localparam logic signed [18:0] RND  = 19'sd1 <<< (SHIFT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                          state;
  logic [STAGES-1:0]               vld_pipe;
  logic [STAGES-1:0][IDX_W-1:0]    idx_pipe;
  logic [7:0]                      qtab [N_COEF];
  logic signed [18:0]              prod_rnd;

  assign prod_rnd = $signed(mul_result) + RND;

  // Block sequencer: issue one read per cycle, then wait for in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      coef_rd   <= 1'b0;
      coef_addr <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state     <= ISSUE;
          busy      <= 1'b1;
          coef_rd   <= 1'b1;
          coef_addr <= '0;
        end
        ISSUE: if (coef_addr == LAST) begin
          state     <= DRAIN;
          coef_rd   <= 1'b0;
          coef_addr <= '0;
        end else begin
          coef_addr <= coef_addr + 1'b1;
        end
        DRAIN: if (vld_pipe == '0) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Quant table. It has no reset, and it is frozen while a block is in flight.
  always_ff @(posedge clk) begin
    if (q_wr_en && !busy) qtab[q_wr_addr] <= q_wr_data;
  end

  // Tracking pipe: {valid, idx} follows each read toward the multiplier output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], coef_rd};
      idx_pipe <= {idx_pipe[STAGES-2:0], coef_addr};
    end
  end

  // Operand register: the coefficient arrives one cycle after its read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_n1 <= '0;
      mul_n2 <= '0;
    end else if (vld_pipe[0]) begin
      mul_n1 <= coef_data;
      mul_n2 <= qtab[idx_pipe[0]];
    end
  end

  // Output stage: round half-up and arithmetic-shift the product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      out_valid <= vld_pipe[STAGES-1];
      done      <= vld_pipe[STAGES-1] && (idx_pipe[STAGES-1] == LAST);
      if (vld_pipe[STAGES-1]) begin
        out_idx  <= idx_pipe[STAGES-1];
        out_data <= 12'(prod_rnd >>> SHIFT);
      end
    end
  end

endmodule

// File: tb/tb_dctq_quant_ctrl.sv
// Directed and random checks for dctq_quant_ctrl, using a behavioural
// 8-stage multiplier and a coefficient buffer.
module tb_dctq_quant_ctrl;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               busy, done, coef_rd, out_valid;
  logic [5:0]         coef_addr, out_idx;
  logic [10:0]        coef_data = '0;
  logic               q_wr_en = 1'b0;
  logic [5:0]         q_wr_addr = '0;
  logic [7:0]         q_wr_data = '0;
  logic [10:0]        mul_n1;
  logic [7:0]         mul_n2;
  logic signed [18:0] mul_result;
  logic [11:0]        out_data;

  dctq_quant_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .coef_rd(coef_rd), .coef_addr(coef_addr), .coef_data(coef_data),
    .q_wr_en(q_wr_en), .q_wr_addr(q_wr_addr), .q_wr_data(q_wr_data),
    .mul_n1(mul_n1), .mul_n2(mul_n2), .mul_result(mul_result),
    .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 8-stage signed multiplier. It has no reset.
  logic signed [18:0] mp [8];
  always @(posedge clk) begin
    mp[0] <= $signed(mul_n1) * $signed(mul_n2);
    for (int i = 1; i < 8; i++) mp[i] <= mp[i-1];
  end
  assign mul_result = mp[7];

  // Coefficient buffer with a one-cycle read.
  logic signed [10:0] cmem [64];
  logic signed [7:0]  qexp [64];
  always @(posedge clk) if (coef_rd) coef_data <= cmem[coef_addr];

  int total = 0, bad = 0;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: round(c*q/128), half-up, built from floor division.
  function automatic int ref_q(input int c, input int q);
    int p, r, rem;
    p = c * q;
    r = p / 128;
    rem = p - r * 128;
    if (rem < 0) begin r--; rem += 128; end
    if (rem >= 64) r++;
    return r;
  endfunction

  // Output monitor
  int t0 = 0, rel, n_out, n_done, exp_idx, first_rd, first_ov, done_cyc;
  int first_busy, last_busy;
  int outbuf [64];

  task automatic clear_mon();
    n_out = 0; n_done = 0; exp_idx = 0; first_rd = -1; first_ov = -1;
    done_cyc = -1; first_busy = -1; last_busy = -1;
    for (int i = 0; i < 64; i++) outbuf[i] = 9999;
  endtask

  always @(negedge clk) if (rst_n) begin
    rel = cyc - t0;
    if (coef_rd && first_rd < 0) first_rd = rel;
    if (busy) begin
      if (first_busy < 0) first_busy = rel;
      last_busy = rel;
    end
    if (out_valid) begin
      if (n_out == 0) first_ov = rel;
      chk("idx_order", int'(out_idx), exp_idx);
      exp_idx++;
      outbuf[out_idx] = $signed(out_data);
      n_out++;
    end
    if (done) begin
      n_done++;
      done_cyc = rel;
      chk("done_with_idx63", out_valid ? int'(out_idx) : -1, 63);
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_coef_rd"}, int'(coef_rd), 0);
    chk({tag, "_coef_addr"}, int'(coef_addr), 0);
    chk({tag, "_mul_n1"}, int'(mul_n1), 0);
    chk({tag, "_mul_n2"}, int'(mul_n2), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_idx"}, int'(out_idx), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
  endtask

  task automatic load_q();
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      q_wr_en = 1'b1; q_wr_addr = 6'(i); q_wr_data = qexp[i];
    end
    @(posedge clk); #1;
    q_wr_en = 1'b0;
  endtask

  // Runs one block over cycles 0..76 relative to the start cycle.
  // pre: start was already driven in the previous call's cycle 76.
  task automatic run_block(input bit pre, input bit extra, input bit midwr,
                           input bit chain, input bit wr0);
    if (!pre) begin
      @(posedge clk); #1;
      start = 1'b1;
      if (wr0) begin
        q_wr_en = 1'b1; q_wr_addr = 6'd0; q_wr_data = 8'sd2; qexp[0] = 8'sd2;
      end
    end
    t0 = cyc;
    clear_mon();
    for (int n = 1; n <= 76; n++) begin
      @(posedge clk); #1;
      start = (extra && (n == 10 || n == 75)) || (chain && n == 76);
      q_wr_en = midwr && (n == 20);
      q_wr_addr = 6'd5; q_wr_data = 8'd1;
    end
    chk("n_out", n_out, 64);
    chk("n_done", n_done, 1);
    chk("first_rd_cycle", first_rd, 1);
    chk("first_ov_cycle", first_ov, 12);
    chk("rd_to_ov_latency", first_ov - first_rd, 11);
    chk("done_cycle", done_cyc, 75);
    chk("busy_first", first_busy, 1);
    chk("busy_last", last_busy, 75);
    chk("busy_at_76", int'(busy), 0);
    for (int i = 0; i < 64; i++)
      chk($sformatf("data[%0d]", i), outbuf[i], ref_q(cmem[i], qexp[i]));
  endtask

  typedef struct { int c; int q; int exp; } vec_t;
  vec_t vt [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{3, 64, 2};        vt[1] = '{-100, 64, -50};
    vt[2] = '{-1024, -128, 1024}; vt[3] = '{0, 37, 0};
    vt[4] = '{-3, 64, -1};      vt[5] = '{100, 64, 50};
    vt[6] = '{1023, 127, 1015}; vt[7] = '{-1, 1, 0};
    vt[8] = '{64, 1, 1};        vt[9] = '{-65, 1, -1};

    // Reset state
    #22;
    check_zero("in_reset");
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check_zero("after_reset");

    // Uniform block: 100 * 64 -> 50
    for (int i = 0; i < 64; i++) begin cmem[i] = 11'sd100; qexp[i] = 8'sd64; end
    load_q();
    run_block(0, 0, 0, 0, 0);

    // Rounding vectors
    for (int i = 0; i < 64; i++) begin cmem[i] = '0; qexp[i] = 8'sd1; end
    for (int i = 0; i < 10; i++) begin cmem[i] = 11'(vt[i].c); qexp[i] = 8'(vt[i].q); end
    load_q();
    run_block(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) chk($sformatf("vec[%0d]", i), outbuf[i], vt[i].exp);

    // Extra starts at 10 and 75 plus a mid-block table write, both ignored;
    // a start in cycle 76 chains straight into the next block.
    for (int i = 0; i < 64; i++) begin cmem[i] = 11'sd100; qexp[i] = 8'sd64; end
    load_q();
    run_block(0, 1, 1, 1, 0);
    chk("midwr_ignored", outbuf[5], 50);
    for (int i = 0; i < 64; i++) cmem[i] = 11'(i * 5 - 160);
    run_block(1, 0, 0, 0, 0);

    // A table write in the start cycle takes effect for this block.
    for (int i = 0; i < 64; i++) cmem[i] = 11'sd100;
    run_block(0, 0, 0, 0, 1);
    chk("wr0_new_value", outbuf[0], 2);

    // Reset in the middle of a block
    for (int i = 0; i < 64; i++) begin cmem[i] = 11'(300 - i * 9); qexp[i] = 8'(i * 3 - 90); end
    load_q();
    @(posedge clk); #1; start = 1'b1;
    t0 = cyc; clear_mon();
    for (int n = 1; n <= 40; n++) begin @(posedge clk); #1; start = 1'b0; end
    chk("pre_rst_outs", n_out, 28);
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    t0 = cyc; clear_mon();
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_out_valid", n_out, 0);
    chk("post_rst_done", n_done, 0);
    chk("post_rst_busy", int'(busy), 0);
    run_block(0, 0, 0, 0, 0);

    // Random blocks
    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < 64; i++) begin
        cmem[i] = 11'($urandom_range(0, 2047));
        qexp[i] = 8'($urandom_range(0, 255));
      end
      load_q();
      run_block(0, 0, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
